// File: rtl/adc_sample_capture.sv
// Periodic SPI-style ADC capture: a free-running sample timer triggers a chip-select framed
// serial read, and each completed word is offered to a downstream FIFO with overflow tracking.
module adc_sample_capture #(
  parameter int unsigned SAMPLE_PERIOD = 1024,
  parameter int unsigned SCK_DIV       = 4,
  parameter int unsigned DATA_BITS     = 16
) (
  input  logic                 CLK_65,
  input  logic                 RST,
  input  logic                 ON,
  input  logic                 FIFO_FULL,
  input  logic                 ADC_MISO,
  output logic                 ADC_SCK,
  output logic                 ADC_CSbar,
  output logic [DATA_BITS-1:0] SAMPLE,
  output logic                 SAMPLE_WR,
  output logic                 OVERFLOW,
  output logic [15:0]          SAMPLE_COUNT
);

  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TimerLast = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DivLast   = DW'(SCK_DIV - 1);
  localparam logic [BW-1:0] BitLast   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StDone
  } state_e;

  state_e               state;
  logic [TW-1:0]        timer;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 run;
  logic                 tick;

  assign run  = ON && !OVERFLOW;
  assign tick = run && (timer == TimerLast);

  // The timer parks at zero whenever capture is disabled or stalled by an overflow.
  always_ff @(posedge CLK_65) begin
    if (RST || !run) begin
      timer <= '0;
    end else if (timer == TimerLast) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge CLK_65) begin
    if (RST) begin
      state        <= StIdle;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      ADC_SCK      <= 1'b0;
      ADC_CSbar    <= 1'b1;
      SAMPLE       <= '0;
      SAMPLE_WR    <= 1'b0;
      OVERFLOW     <= 1'b0;
      SAMPLE_COUNT <= '0;
    end else if (!ON) begin
      // Abort: release the ADC immediately but keep the last good sample and count.
      state     <= StIdle;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      ADC_SCK   <= 1'b0;
      ADC_CSbar <= 1'b1;
      SAMPLE_WR <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      SAMPLE_WR <= 1'b0;
      unique case (state)
        StIdle: begin
          if (tick) begin
            state     <= StCsSetup;
            ADC_CSbar <= 1'b0;
            div_cnt   <= '0;
          end
        end
        StCsSetup: begin
          if (div_cnt == DivLast) begin
            state   <= StShift;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        StShift: begin
          if (div_cnt == DivLast) begin
            div_cnt <= '0;
            if (!ADC_SCK) begin
              // Data is taken on the edge that raises SCK, MSB first.
              ADC_SCK <= 1'b1;
              shreg   <= {shreg[DATA_BITS-2:0], ADC_MISO};
            end else begin
              ADC_SCK <= 1'b0;
              if (bit_cnt == BitLast) begin
                state <= StCsHold;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        StCsHold: begin
          if (div_cnt == DivLast) begin
            state     <= StDone;
            div_cnt   <= '0;
            ADC_CSbar <= 1'b1;
            SAMPLE    <= shreg;
            if (FIFO_FULL || OVERFLOW) begin
              OVERFLOW <= 1'b1;
            end else begin
              SAMPLE_WR    <= 1'b1;
              SAMPLE_COUNT <= SAMPLE_COUNT + 16'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture with a behavioural SPI ADC that shifts a preset word.
module tb_adc_sample_capture;

  logic        CLK_65 = 1'b0;
  logic        RST = 1'b1;
  logic        ON = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        ADC_MISO = 1'b0;
  logic        ADC_SCK;
  logic        ADC_CSbar;
  logic [15:0] SAMPLE;
  logic        SAMPLE_WR;
  logic        OVERFLOW;
  logic [15:0] SAMPLE_COUNT;

  int n_total = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] miso_word = 16'h0000;
  int          rises = 0;
  int          rise_total = 0;
  int          first_rise = 0;
  int          last_rise = 0;
  int          cs_falls = 0;
  int          wr_count = 0;
  logic        sck_d = 1'b0;
  logic        cs_d = 1'b1;

  int t0, t1, t2, t3, r0, c0, w0;

  adc_sample_capture dut (
    .CLK_65       (CLK_65),
    .RST          (RST),
    .ON           (ON),
    .FIFO_FULL    (FIFO_FULL),
    .ADC_MISO     (ADC_MISO),
    .ADC_SCK      (ADC_SCK),
    .ADC_CSbar    (ADC_CSbar),
    .SAMPLE       (SAMPLE),
    .SAMPLE_WR    (SAMPLE_WR),
    .OVERFLOW     (OVERFLOW),
    .SAMPLE_COUNT (SAMPLE_COUNT)
  );

  always #5 CLK_65 = ~CLK_65;

  always @(posedge CLK_65) cyc <= cyc + 1;

  // ADC model: presents bit k until the k-th SCK rise, then moves to the next bit.
  always @(negedge CLK_65) begin
    if (ADC_CSbar) begin
      rises = 0;
    end else if (ADC_SCK && !sck_d) begin
      if (rises == 0) first_rise = cyc;
      last_rise = cyc;
      rises++;
      rise_total++;
    end
    if (!ADC_CSbar && cs_d) cs_falls++;
    if (SAMPLE_WR) wr_count++;
    sck_d = ADC_SCK;
    cs_d  = ADC_CSbar;
    ADC_MISO = (rises < 16) ? miso_word[4'(15 - rises)] : 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK_65);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    step(3);
    chk("rst_csbar", 32'(ADC_CSbar), 32'd1);
    chk("rst_sck", 32'(ADC_SCK), 32'd0);
    chk("rst_sample", 32'(SAMPLE), 32'd0);
    chk("rst_wr", 32'(SAMPLE_WR), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_count", 32'(SAMPLE_COUNT), 32'd0);

    // Single conversion of 0xA5C3
    miso_word = 16'hA5C3;
    RST = 1'b0;
    ON = 1'b1;
    t0 = cyc;
    r0 = rise_total;
    step(1023);
    chk("cs_before_tick", 32'(ADC_CSbar), 32'd1);
    step(1);
    chk("cs_after_tick", 32'(ADC_CSbar), 32'd0);
    chk("sck_setup", 32'(ADC_SCK), 32'd0);
    step(135);
    chk("wr_early", 32'(SAMPLE_WR), 32'd0);
    step(1);
    chk("wr_137", 32'(SAMPLE_WR), 32'd1);
    chk("sample_a5c3", 32'(SAMPLE), 32'h0000A5C3);
    chk("count_1", 32'(SAMPLE_COUNT), 32'd1);
    chk("cs_done", 32'(ADC_CSbar), 32'd1);
    chk("first_rise", 32'(first_rise - t0), 32'd1032);
    chk("rise_span", 32'(last_rise - first_rise), 32'd120);
    chk("rise_count", 32'(rise_total - r0), 32'd16);
    step(1);
    chk("wr_one_cycle", 32'(SAMPLE_WR), 32'd0);

    // Three more ticks, strobes 1024 cycles apart
    miso_word = 16'h0001;
    step(1023);
    chk("wr_2", 32'(SAMPLE_WR), 32'd1);
    chk("sample_0001", 32'(SAMPLE), 32'h00000001);
    miso_word = 16'h8000;
    step(1024);
    chk("wr_3", 32'(SAMPLE_WR), 32'd1);
    chk("sample_8000", 32'(SAMPLE), 32'h00008000);
    miso_word = 16'hFFFF;
    step(1024);
    chk("wr_4", 32'(SAMPLE_WR), 32'd1);
    chk("sample_ffff", 32'(SAMPLE), 32'h0000FFFF);
    chk("count_4", 32'(SAMPLE_COUNT), 32'd4);
    chk("wr_total_4", 32'(wr_count), 32'd4);

    // Overflow: FIFO full at DONE
    miso_word = 16'h1234;
    FIFO_FULL = 1'b1;
    step(1024);
    chk("ovf_no_wr", 32'(SAMPLE_WR), 32'd0);
    chk("ovf_set", 32'(OVERFLOW), 32'd1);
    chk("ovf_count", 32'(SAMPLE_COUNT), 32'd4);
    FIFO_FULL = 1'b0;
    c0 = cs_falls;
    step(3000);
    chk("ovf_no_cs", 32'(cs_falls - c0), 32'd0);
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);
    chk("ovf_wr_total", 32'(wr_count), 32'd4);
    ON = 1'b0;
    step(1);
    chk("ovf_clear", 32'(OVERFLOW), 32'd0);
    ON = 1'b1;
    t1 = cyc;
    miso_word = 16'h5A5A;
    step(1160);
    chk("resume_wr", 32'(SAMPLE_WR), 32'd1);
    chk("resume_sample", 32'(SAMPLE), 32'h00005A5A);
    chk("resume_count", 32'(SAMPLE_COUNT), 32'd5);

    // Abort 40 cycles into SHIFT
    miso_word = 16'hFFFF;
    step(932);
    chk("abort_inflight", 32'(ADC_CSbar), 32'd0);
    ON = 1'b0;
    step(1);
    chk("abort_cs", 32'(ADC_CSbar), 32'd1);
    chk("abort_sck", 32'(ADC_SCK), 32'd0);
    chk("abort_wr", 32'(SAMPLE_WR), 32'd0);
    chk("abort_sample", 32'(SAMPLE), 32'h00005A5A);
    w0 = wr_count;
    step(200);
    chk("abort_no_wr", 32'(wr_count - w0), 32'd0);
    chk("abort_count", 32'(SAMPLE_COUNT), 32'd5);

    // Reset mid-SHIFT
    ON = 1'b1;
    t2 = cyc;
    step(1060);
    chk("rst_inflight", 32'(ADC_CSbar), 32'd0);
    RST = 1'b1;
    step(1);
    chk("mid_rst_cs", 32'(ADC_CSbar), 32'd1);
    chk("mid_rst_sck", 32'(ADC_SCK), 32'd0);
    chk("mid_rst_sample", 32'(SAMPLE), 32'd0);
    chk("mid_rst_wr", 32'(SAMPLE_WR), 32'd0);
    chk("mid_rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("mid_rst_count", 32'(SAMPLE_COUNT), 32'd0);
    RST = 1'b0;
    t3 = cyc;
    miso_word = 16'h0F0F;
    step(1023);
    chk("post_rst_no_tick", 32'(ADC_CSbar), 32'd1);
    step(1);
    chk("post_rst_tick", 32'(ADC_CSbar), 32'd0);
    step(136);
    chk("post_rst_wr", 32'(SAMPLE_WR), 32'd1);
    chk("post_rst_sample", 32'(SAMPLE), 32'h00000F0F);
    chk("post_rst_count", 32'(SAMPLE_COUNT), 32'd1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
